// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared types and constants for the UART receiver slice.
//
// Contents:
//   DEFAULT_CLKS_PER_BIT : default bit period in clk cycles (50 MHz / 115200)
//   DATA_W               : payload width carried on the receive interface
//   S_* constants        : receiver state encodings
//   uart_state_e         : receiver state type built on the S_* encodings
//
// Build option: UART_RX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_W               = 8;

    // Fixed encodings so the state register value is stable across builds.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_START     = S_START,
        ST_DATA      = S_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = S_PARITY,
`endif
        ST_STOP      = S_STOP,
        ST_WAIT_IDLE = S_WAIT_IDLE
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if -- serial input and byte-output handshake of the UART receiver.
//
// Signals:
//   rxd        : serial line, idle high, asynchronous to clk
//   data_out   : received byte, stable while data_valid = 1
//   data_valid : byte available, held until data_valid & data_ready
//   data_ready : consumer accepts the byte
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, completed byte dropped because buffer full
//   parity_err : one-cycle pulse, parity mismatch (0 unless UART_RX_PARITY_EN)
//
// Modports: slave = receiver side, master = line driver / byte consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic              rxd;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              frame_err;
    logic              overrun;
    logic              parity_err;

    modport slave (
        input  rxd,
        input  data_ready,
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output parity_err
    );

    modport master (
        output rxd,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  parity_err
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff -- two-flop synchronizer for a single asynchronous input.
//
// Parameters:
//   RST_VAL : value both flops take during reset
// Ports:
//   clk  : destination clock
//   rst  : asynchronous active-high reset
//   i_d  : asynchronous input
//   o_q  : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with a one-byte output buffer.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per bit, 8..65535
//   DATA_BITS    : payload bits per frame (8)
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : uart_rx_if.slave (rxd in, byte handshake and error pulses out)
//
// Build option: define UART_RX_PARITY_EN to receive one even-parity bit
// between the data bits and the stop bit. Without it parity_err is tied 0.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DATA_W
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    uart_state_e          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic [DATA_W-1:0]    r_data_out;
    logic                 r_data_valid;
    logic                 r_overrun;

    logic                 w_rxd;
    logic                 w_half_tick;
    logic                 w_bit_tick;
    logic                 w_byte_done;

    // ---------------------------------------------------------------------
    // Input synchronizer; idle-high reset value so reset never looks like
    // a start bit.
    // ---------------------------------------------------------------------
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.rxd),
        .o_q (w_rxd)
    );

    // START samples at mid-bit; every later sample is a full bit after the
    // previous one, so the sample point stays centred on each bit.
    assign w_half_tick = (r_cnt == HALF_LAST);
    assign w_bit_tick  = (r_cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;

    assign w_byte_done = (r_state == ST_STOP) && w_bit_tick && w_rxd && !r_par_bad;
    assign bus.parity_err = r_parity_err;
`else
    assign w_byte_done = (r_state == ST_STOP) && w_bit_tick && w_rxd;
    assign bus.parity_err = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                    r_par_bad <= 1'b0;
`endif
                    if (!w_rxd) r_state <= ST_START;
                end

                ST_START: begin
                    if (w_half_tick) begin
                        r_cnt <= '0;
                        // A line back high at mid-start is a glitch: drop silently.
                        r_state <= w_rxd ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_bit_tick) begin
                        r_cnt     <= '0;
                        // LSB first: new bits enter at the top and shift down.
                        r_shift   <= {w_rxd, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_tick) begin
                        r_cnt   <= '0;
                        r_state <= ST_STOP;
                        // Even parity: data bits plus parity bit have even weight.
                        if (w_rxd != (^r_shift)) begin
                            r_par_bad    <= 1'b1;
                            r_parity_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_bit_tick) begin
                        r_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        r_par_bad <= 1'b0;
`endif
                        if (w_rxd) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Hold off until the line returns high so a break reports
                // a single frame error instead of a stream of them.
                ST_WAIT_IDLE: begin
                    r_cnt <= '0;
                    if (w_rxd) r_state <= ST_IDLE;
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // One-byte output buffer. A completed byte loads when the buffer is
    // empty or is being drained in the same cycle; otherwise it is dropped
    // and flagged, keeping the byte the consumer has not yet taken.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_byte_done) begin
                if (!r_data_valid || bus.data_ready) begin
                    r_data_out   <= r_shift;
                    r_data_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_data_valid && bus.data_ready) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx at 16 clks per bit.
// Works in both builds; the parity scenario only runs with UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if u_if ();

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Event counters, updated only by the monitor.
    int         n_fe = 0, n_ov = 0, n_pe = 0, n_hs = 0, n_vcyc = 0;
    logic [7:0] last_hs = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.frame_err)  n_fe++;
            if (u_if.overrun)    n_ov++;
            if (u_if.parity_err) n_pe++;
            if (u_if.data_valid) n_vcyc++;
            if (u_if.data_valid && u_if.data_ready) begin
                n_hs++;
                last_hs = u_if.data_out;
            end
        end
    end

    // Snapshots taken by the stimulus process.
    int b_fe, b_ov, b_pe, b_hs, b_vcyc;

    task automatic snap();
        b_fe = n_fe; b_ov = n_ov; b_pe = n_pe; b_hs = n_hs; b_vcyc = n_vcyc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        u_if.rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int bits);
        u_if.rxd = 1'b1;
        repeat (bits * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(par_b);
`else
        if (par_b) begin end
`endif
        bit_time(stop_b);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, 1'b1, ^b);
    endtask

    initial begin
        u_if.rxd        = 1'b1;
        u_if.data_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_data_out",   32'(u_if.data_out),   32'h00);
        chk("rst_data_valid", 32'(u_if.data_valid), 32'h0);
        chk("rst_frame_err",  32'(u_if.frame_err),  32'h0);
        chk("rst_overrun",    32'(u_if.overrun),    32'h0);
        chk("rst_parity_err", 32'(u_if.parity_err), 32'h0);
        rst = 1'b0;
        idle(2);

        // 0x55 with consumer ready: one valid cycle, no errors
        snap();
        send_ok(8'h55);
        idle(2);
        chk("b55_valid_cycles", 32'(n_vcyc - b_vcyc), 32'd1);
        chk("b55_handshakes",   32'(n_hs - b_hs),     32'd1);
        chk("b55_data",         32'(last_hs),         32'h55);
        chk("b55_frame_err",    32'(n_fe - b_fe),     32'd0);
        chk("b55_overrun",      32'(n_ov - b_ov),     32'd0);
        chk("b55_valid_low",    32'(u_if.data_valid), 32'h0);

        // 0xA3 then 0x3C with consumer stalled: second byte overruns
        u_if.data_ready = 1'b0;
        snap();
        send_ok(8'hA3);
        idle(1);
        send_ok(8'h3C);
        idle(2);
        chk("ovr_data_out",  32'(u_if.data_out),   32'hA3);
        chk("ovr_valid",     32'(u_if.data_valid), 32'h1);
        chk("ovr_count",     32'(n_ov - b_ov),     32'd1);
        chk("ovr_frame_err", 32'(n_fe - b_fe),     32'd0);
        u_if.data_ready = 1'b1;
        @(negedge clk);
        chk("ovr_drained_valid", 32'(u_if.data_valid), 32'h0);
        @(negedge clk);
        chk("ovr_drain_hs",   32'(n_hs - b_hs), 32'd1);
        chk("ovr_drain_data", 32'(last_hs),     32'hA3);

        // 0x81 with bad stop, then 40-bit break, then recovery with 0x7E
        snap();
        send_frame(8'h81, 1'b0, ^8'h81);
        u_if.rxd = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        idle(2);
        chk("brk_frame_err", 32'(n_fe - b_fe),     32'd1);
        chk("brk_no_valid",  32'(n_vcyc - b_vcyc), 32'd0);
        snap();
        send_ok(8'h7E);
        idle(2);
        chk("rec_hs",        32'(n_hs - b_hs), 32'd1);
        chk("rec_data",      32'(last_hs),     32'h7E);
        chk("rec_frame_err", 32'(n_fe - b_fe), 32'd0);

        // 5-cycle glitch on idle line is rejected
        snap();
        u_if.rxd = 1'b0;
        repeat (5) @(negedge clk);
        idle(3);
        chk("gl_no_valid",  32'(n_vcyc - b_vcyc), 32'd0);
        chk("gl_frame_err", 32'(n_fe - b_fe),     32'd0);
        chk("gl_overrun",   32'(n_ov - b_ov),     32'd0);
        send_ok(8'h5A);
        idle(2);
        chk("gl_next_hs",   32'(n_hs - b_hs), 32'd1);
        chk("gl_next_data", 32'(last_hs),     32'h5A);

        // Reset during bit 4 of 0xF0, then 0x0F
        snap();
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b0);
        u_if.rxd = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_data_out", 32'(u_if.data_out), 32'h00);
        rst = 1'b0;
        idle(6);
        chk("mrst_no_valid", 32'(n_vcyc - b_vcyc), 32'd0);
        send_ok(8'h0F);
        idle(2);
        chk("mrst_hs",        32'(n_hs - b_hs), 32'd1);
        chk("mrst_data",      32'(last_hs),     32'h0F);
        chk("mrst_frame_err", 32'(n_fe - b_fe), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so the even-parity bit must be 1
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(2);
        chk("par_bad_pe",    32'(n_pe - b_pe),     32'd1);
        chk("par_bad_valid", 32'(n_vcyc - b_vcyc), 32'd0);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2);
        chk("par_ok_pe",   32'(n_pe - b_pe), 32'd0);
        chk("par_ok_hs",   32'(n_hs - b_hs), 32'd1);
        chk("par_ok_data", 32'(last_hs),     32'h07);
`else
        chk("par_tied_off", 32'(n_pe), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 8..65535.
REQ-002 SHALL provide parameter DATA_BITS, default 8, payload bits per frame; fixed at 8 in this revision.
REQ-003 SHALL provide port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-006 SHALL provide port data_out  output  8  received byte, stable while data_valid=1.
REQ-007 SHALL provide port data_valid  output  1  byte available; held until accepted.
REQ-008 SHALL provide port data_ready  input  1  consumer accepts byte when data_valid & data_ready.
REQ-009 SHALL provide port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL provide port overrun  output  1  one-cycle pulse, new byte dropped because buffer full.
REQ-011 SHALL provide port parity_err  output  1  one-cycle pulse, parity mismatch (see Configuration).

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer (reset value 1) before any use; 2-cycle input latency.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-014 IDLE -> START on synchronized rxd = 0; bit counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer divide) sample; 0 -> DATA, 1 -> IDLE (glitch rejected, no error pulse).
REQ-016 DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 samples into shift register, then -> PARITY if enabled else STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; 1 -> byte complete, -> IDLE; 0 -> frame_err pulse, byte discarded, -> WAIT_IDLE.
REQ-018 WAIT_IDLE -> IDLE only when synchronized rxd = 1 (break conditions produce exactly one frame_err).
REQ-019 On byte complete: if data_valid=0, or data_valid & data_ready in the same cycle, load data_out and assert data_valid next cycle.
REQ-020 On byte complete with data_valid=1 and data_ready=0: keep old data_out, pulse overrun, drop new byte.
REQ-021 data_valid SHALL deassert the cycle after data_valid & data_ready, unless REQ-019 reload coincides.
REQ-022 Receiver SHALL keep sampling regardless of data_ready; no backpressure on line.
REQ-023 Bit-period counter width SHALL be $clog2(CLKS_PER_BIT); counter reloads each bit, no cumulative drift beyond one cycle per bit.

Reset
REQ-024 rst SHALL asynchronously force: state IDLE, counters 0, shift register 0, data_out 0x00, data_valid 0, all error pulses 0, synchronizer flops 1.
REQ-025 rst asserted mid-frame SHALL abandon the frame; after release, the next falling edge starts a new frame.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: PARITY state present, one even-parity bit sampled after data; mismatch -> parity_err pulse, byte discarded, STOP still checked.
REQ-027 Macro UART_RX_PARITY_EN undefined: no PARITY state, DATA -> STOP directly, parity_err tied 0.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enum type and the default CLKS_PER_BIT constant.
REQ-029 Synchronizer SHALL be sub-module sync_2ff (parameterized reset value); all else in uart_rx.

Verification (CLKS_PER_BIT=16 in bench)
REQ-030 Frame 0x55, data_ready=1 -> data_valid pulses 1 cycle, data_out=0x55, no error pulses.
REQ-031 Frames 0xA3 then 0x3C, data_ready=0 throughout -> data_out stays 0xA3, one overrun pulse at second stop sample, data_valid stays 1.
REQ-032 Frame 0x81 with stop bit 0, then line low 40 bit times -> exactly one frame_err, no data_valid, receiver recovers on next valid frame 0x7E.
REQ-033 rxd low pulse of 5 cycles on idle line -> no data_valid, no error, state back to IDLE.
REQ-034 rst asserted at DATA bit 4 of 0xF0 for 3 cycles, then frame 0x0F -> only 0x0F delivered.
REQ-035 With UART_RX_PARITY_EN: frame 0x07 with parity bit 0 -> parity_err pulse, no data_valid; parity bit 1 -> data_out=0x07.
